jk_counter: RTL and testbench

- Parametrised WIDTH-bit bank of JK flip-flops; the multi-bit successor of the single-bit JK trigger.
- Four modes:
  - per-bit JK drive
  - binary up-count
  - binary down-count
  - parallel load
- Count modes are built from toggle-enabled JK cells, not from an adder.
- Used wherever the design needs a settable/clearable register or a small synchronous counter with a terminal-count flag.

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_cell.sv | 28 ++
 rtl/jk_counter.sv | 101 ++++++++++
 tb/tb_jk_counter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - mode encodings and per-cell JK actions for the jk_counter bank
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } jk_mode_t;

  // JK cell actions, indexed by {j,k}
  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] CLEAR  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with clock enable and async active-low reset
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK characteristic: hold / clear / set / toggle, gated by en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= rst_val;
    end else if (en) begin
      case ({j, k})
        HOLD:    q <= q;
        CLEAR:   q <= 1'b0;
        SET:     q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter.sv
// rtl/jk_counter.sv - WIDTH-bit JK register/counter; JK_COUNTER_SATURATE_EN makes UP/DOWN saturate
module jk_counter
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  jk_mode_t         mode_e;
  logic [WIDTH-1:0] tog_up;
  logic [WIDTH-1:0] tog_dn;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             all_ones;
  logic             all_zero;
  logic             run_ones;
  logic             run_zero;

  assign mode_e = jk_mode_t'(mode);

  // Ripple toggle-enable chains: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    tog_up   = '0;
    tog_dn   = '0;
    run_ones = 1'b1;
    run_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tog_up[i] = run_ones;
      tog_dn[i] = run_zero;
      run_ones  = run_ones & q[i];
      run_zero  = run_zero & ~q[i];
    end
    all_ones = run_ones;
    all_zero = run_zero;
  end

  // Steer per-cell j/k from the selected mode
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    case (mode_e)
      MODE_JK: begin
        cell_j = j;
        cell_k = k;
      end
      MODE_UP: begin
`ifdef JK_COUNTER_SATURATE_EN
        if (!all_ones) begin
          cell_j = tog_up;
          cell_k = tog_up;
        end
`else
        cell_j = tog_up;
        cell_k = tog_up;
`endif
      end
      MODE_DOWN: begin
`ifdef JK_COUNTER_SATURATE_EN
        if (!all_zero) begin
          cell_j = tog_dn;
          cell_k = tog_dn;
        end
`else
        cell_j = tog_dn;
        cell_k = tog_dn;
`endif
      end
      default: begin
        cell_j = load_val;
        cell_k = ~load_val;
      end
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RESET_VAL[g]),
      .en      (en),
      .j       (cell_j[g]),
      .k       (cell_k[g]),
      .q       (q[g])
    );
  end

  assign qn = ~q;
  assign tc = en & (((mode_e == MODE_UP) & all_ones) | ((mode_e == MODE_DOWN) & all_zero));

endmodule

// File: tb/tb_jk_counter.sv
// tb/tb_jk_counter.sv - directed and randomized bench for jk_counter against an arithmetic model
module tb_jk_counter;

  localparam int               W  = 8;
  localparam logic [W-1:0]     RV = 8'hA5;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         tc;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] mq;

  always #5 clk = ~clk;

  jk_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .j        (j),
    .k        (k),
    .load_val (load_val),
    .q        (q),
    .qn       (qn),
    .tc       (tc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic [1:0] m,
                                            input logic [W-1:0] jj, input logic [W-1:0] kk,
                                            input logic [W-1:0] lv);
    logic [W-1:0] ones;
    ones = '1;
    case (m)
      2'd0: return (jj & ~cur) | (~kk & cur);
      2'd1: begin
`ifdef JK_COUNTER_SATURATE_EN
        if (cur == ones) return cur;
`endif
        return cur + 1'b1;
      end
      2'd2: begin
`ifdef JK_COUNTER_SATURATE_EN
        if (cur == '0) return cur;
`endif
        return cur - 1'b1;
      end
      default: return lv;
    endcase
  endfunction

  function automatic logic ref_tc(input logic [W-1:0] cur, input logic e, input logic [1:0] m);
    logic [W-1:0] ones;
    ones = '1;
    return e & (((m == 2'd1) && (cur == ones)) || ((m == 2'd2) && (cur == '0)));
  endfunction

  task automatic drive(input logic e, input logic [1:0] m, input logic [W-1:0] jj,
                       input logic [W-1:0] kk, input logic [W-1:0] lv);
    en = e; mode = m; j = jj; k = kk; load_val = lv;
  endtask

  // Check tc before the edge, advance the model on the edge, then check q/qn
  task automatic cyc(input string tag);
    #1;
    check({tag, ".tc"}, {31'd0, tc}, {31'd0, ref_tc(mq, en, mode)});
    @(posedge clk);
    if (en) mq = ref_next(mq, mode, j, k, load_val);
    #1;
    check({tag, ".q"}, {24'd0, q}, {24'd0, mq});
    check({tag, ".qn"}, {24'd0, qn}, {24'd0, ~mq});
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 2'd1, '0, '0, '0);

    // Asynchronous reset between edges; edges during reset are ignored
    #2 reset = 1'b0;
    #1;
    check("rst.q", {24'd0, q}, {24'd0, RV});
    check("rst.qn", {24'd0, qn}, 32'h5A);
    mq = RV;
    repeat (2) @(posedge clk);
    #1;
    check("rst.hold", {24'd0, q}, {24'd0, RV});
    reset = 1'b1;

    // JK mode
    drive(1'b1, 2'd3, '0, '0, 8'h00); cyc("load00");
    drive(1'b1, 2'd0, 8'hF0, 8'h0F, 8'h5C); cyc("jk_set");
    check("jk_set.const", {24'd0, q}, 32'hF0);
    drive(1'b1, 2'd0, 8'hFF, 8'hFF, 8'h00); cyc("jk_tog");
    check("jk_tog.const", {24'd0, q}, 32'h0F);
    drive(1'b1, 2'd0, 8'h00, 8'h00, 8'hFF);
    repeat (3) cyc("jk_hold");
    check("jk_hold.const", {24'd0, q}, 32'h0F);

    // UP wrap
    drive(1'b1, 2'd3, '0, '0, 8'hFD); cyc("load_fd");
    drive(1'b1, 2'd1, 8'hAA, 8'h55, 8'h00);
    cyc("up1"); check("up1.const", {24'd0, q}, 32'hFE);
    cyc("up2"); check("up2.const", {24'd0, q}, 32'hFF);
    #1 check("up_tc_ff", {31'd0, tc}, 32'd1);
    cyc("up3");
`ifdef JK_COUNTER_SATURATE_EN
    check("up3.const", {24'd0, q}, 32'hFF);
`else
    check("up3.const", {24'd0, q}, 32'h00);
`endif

    // DOWN wrap
    drive(1'b1, 2'd3, '0, '0, 8'h01); cyc("load_01");
    drive(1'b1, 2'd2, 8'h0F, 8'hF0, 8'h33);
    cyc("dn1"); check("dn1.const", {24'd0, q}, 32'h00);
    #1 check("dn_tc_00", {31'd0, tc}, 32'd1);
    cyc("dn2");
    cyc("dn3");
`ifdef JK_COUNTER_SATURATE_EN
    check("dn3.const", {24'd0, q}, 32'h00);
`else
    check("dn3.const", {24'd0, q}, 32'hFE);
`endif

    // Enable gating
    drive(1'b1, 2'd3, '0, '0, 8'h10); cyc("load_10");
    drive(1'b0, 2'd1, '0, '0, '0);
    repeat (4) cyc("en_off");
    check("en_off.const", {24'd0, q}, 32'h10);
    check("en_off.tc", {31'd0, tc}, 32'd0);
    drive(1'b1, 2'd1, '0, '0, '0); cyc("en_on");
    check("en_on.const", {24'd0, q}, 32'h11);

    // Reset mid-count
    drive(1'b1, 2'd3, '0, '0, 8'h00); cyc("load_00b");
    drive(1'b1, 2'd1, '0, '0, '0);
    repeat (5) cyc("cnt");
    #1 reset = 1'b0;
    #1 check("midrst.q", {24'd0, q}, {24'd0, RV});
    mq = RV;
    #1 reset = 1'b1;
    cyc("after_rst");
    check("after_rst.const", {24'd0, q}, {24'd0, RV + 8'd1});

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        #1 reset = 1'b0;
        #1 check("rnd_rst.q", {24'd0, q}, {24'd0, RV});
        mq = RV;
        #1 reset = 1'b1;
      end
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            W'($urandom), W'($urandom), W'($urandom));
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
